// File: rtl/sw_debounce5_pkg.sv
// Shared constants for the five-switch debouncer: debounce lengths and
// the mapping from sw[] bit positions to the A..E outputs.
package debounce_defs;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned DEBOUNCE_CYCLES_BENCH   = 4;

  localparam int unsigned NUM_SW = 5;

  localparam int unsigned IDX_A = 4;
  localparam int unsigned IDX_B = 3;
  localparam int unsigned IDX_C = 2;
  localparam int unsigned IDX_D = 1;
  localparam int unsigned IDX_E = 0;

  typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce5_if.sv
// Switch bundle between the raw board switches and the First_M inputs.
interface sw_debounce5_if;
  import debounce_defs::*;

  sw_vec_t sw;
  logic    A;
  logic    B;
  logic    C;
  logic    D;
  logic    E;
  logic    changed;
  logic    stable;

  modport master (
    output sw,
    input  A, B, C, D, E, changed, stable
  );

  modport slave (
    input  sw,
    output A, B, C, D, E, changed, stable
  );

endinterface

// File: rtl/sw_debounce5_bit.sv
// One debounced switch: two-flop synchronizer, saturating persistence
// counter and the accepted level q.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic accept,
  output logic settled
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             q_q,  q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = d_in;
    s2_d    = s1_q;
    settled = (s2_q == q_q);
    accept  = !settled && (cnt_q == CNT_LAST);
    q_d     = q_q;
    cnt_d   = '0;
    // Any return to q, or acceptance, restarts the count from zero.
    if (accept) begin
      q_d = s2_q;
    end else if (!settled) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sw_debounce5.sv
// Five independent switch debouncers feeding First_M, with a single
// registered change strobe and a combined settled indication.
module sw_debounce5
  import debounce_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic           clk,
  input  logic           rst_n,
  sw_debounce5_if.slave  bus
);

  sw_vec_t q_vec;
  sw_vec_t accept_vec;
  sw_vec_t settled_vec;
  logic    changed_q, changed_d;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_in    (bus.sw[i]),
      .q       (q_vec[i]),
      .accept  (accept_vec[i]),
      .settled (settled_vec[i])
    );
  end

  // Simultaneous acceptances collapse into one strobe aligned with q.
  always_comb begin
    changed_d = |accept_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign bus.A       = q_vec[IDX_A];
  assign bus.B       = q_vec[IDX_B];
  assign bus.C       = q_vec[IDX_C];
  assign bus.D       = q_vec[IDX_D];
  assign bus.E       = q_vec[IDX_E];
  assign bus.changed = changed_q;
  assign bus.stable  = &settled_vec;

endmodule

// File: tb/tb_sw_debounce5.sv
// Directed bench for sw_debounce5 with a 4-cycle debounce window.
module tb_sw_debounce5;
  import debounce_defs::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [4:0] out_v;

  sw_debounce5_if bus ();

  sw_debounce5 #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_BENCH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign out_v = {bus.A, bus.B, bus.C, bus.D, bus.E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // 1: reset with all switches high, then release
    rst_n  = 1'b0;
    bus.sw = 5'b11111;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_out", 8'(out_v), 8'h00);
    chk("rst_changed", 8'(bus.changed), 8'h00);
    chk("rst_stable", 8'(bus.stable), 8'h01);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t1_out_e%0d", e), 8'(out_v), (e >= 6) ? 8'h1f : 8'h00);
      chk($sformatf("t1_chg_e%0d", e), 8'(bus.changed), 8'(e == 6));
    end

    // return to all-zero
    bus.sw = 5'b00000;
    for (int i = 0; i < 10; i++) tick();
    chk("clear_out", 8'(out_v), 8'h00);
    chk("clear_stable", 8'(bus.stable), 8'h01);

    // 2: B and D rise together
    bus.sw = 5'b01010;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t2_out_e%0d", e), 8'(out_v), (e >= 6) ? 8'h0a : 8'h00);
      chk($sformatf("t2_chg_e%0d", e), 8'(bus.changed), 8'(e == 6));
      chk($sformatf("t2_stb_e%0d", e), 8'(bus.stable), 8'(!(e >= 2 && e <= 5)));
    end

    // 3: 3-cycle glitch on sw[0] is rejected
    bus.sw = 5'b01011;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) bus.sw = 5'b01010;
      tick();
      chk($sformatf("t3_out_e%0d", e), 8'(out_v), 8'h0a);
      chk($sformatf("t3_chg_e%0d", e), 8'(bus.changed), 8'h00);
      chk($sformatf("t3_stb_e%0d", e), 8'(bus.stable), 8'(!(e >= 2 && e <= 4)));
    end

    // 4: multi-bit update on one edge
    bus.sw = 5'b11001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t4_out_e%0d", e), 8'(out_v), (e >= 6) ? 8'h19 : 8'h0a);
      chk($sformatf("t4_chg_e%0d", e), 8'(bus.changed), 8'(e == 6));
    end

    // clear again so A starts at 0
    bus.sw = 5'b00000;
    for (int i = 0; i < 10; i++) tick();
    chk("clear2_out", 8'(out_v), 8'h00);

    // 5: bouncing sw[4], then held high
    for (int c = 0; c < 20; c++) begin
      bus.sw = {((c / 2) % 2 == 0), 4'b0000};
      tick();
      chk($sformatf("t5_bounce_A_c%0d", c), 8'(bus.A), 8'h00);
      chk($sformatf("t5_bounce_chg_c%0d", c), 8'(bus.changed), 8'h00);
    end
    bus.sw = 5'b10000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("t5_out_e%0d", e), 8'(out_v), (e >= 6) ? 8'h10 : 8'h00);
      chk($sformatf("t5_chg_e%0d", e), 8'(bus.changed), 8'(e == 6));
    end

    // 6: reset mid-count discards progress
    bus.sw = 5'b00100;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("t6_pre_out_e%0d", e), 8'(out_v), 8'h10);
    end
    rst_n = 1'b0;
    tick();
    chk("t6_rst_out", 8'(out_v), 8'h00);
    chk("t6_rst_chg", 8'(bus.changed), 8'h00);
    chk("t6_rst_stb", 8'(bus.stable), 8'h01);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("t6_out_e%0d", e), 8'(out_v), (e >= 6) ? 8'h04 : 8'h00);
      chk($sformatf("t6_chg_e%0d", e), 8'(bus.changed), 8'(e == 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
